// File: rtl/prio_arbiter_hold.sv
// Registered N-way priority arbiter that holds each grant until release, with a hold watchdog.
// Define PRIO_ARB_ROUND_ROBIN_EN to replace fixed priority with rotating priority.
module prio_arbiter_hold #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;

    logic             rel_drop;
    logic             rel_wd;
    logic             rel_any;
    logic             wd_only;
    logic [N-1:0]     arb_vec;
    logic             win_any;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_oh;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    // Index that currently has top priority; search descends from here with wrap.
    logic [IDX_W-1:0] ptr;
`endif

    assign rel_drop = ~|(req & gnt);
    assign rel_wd   = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign rel_any  = (state == GRANT) && (done || rel_drop || rel_wd);
    assign wd_only  = rel_wd && !done && !rel_drop;
    // A timed-out owner must not win the same edge it was evicted on.
    assign arb_vec  = wd_only ? (req & ~gnt) : req;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin : pick
        int p;
        win_any = 1'b0;
        win_idx = '0;
        p       = 0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            p = int'(ptr) - k;
            if (p < 0) p = p + N;
            if (!win_any && arb_vec[p]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(p);
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (arb_vec[i]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
`endif
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            ptr       <= IDX_W'(N - 1);
`endif
        end else if (state == IDLE || rel_any) begin
            timeout  <= rel_any && wd_only;
            hold_cnt <= '0;
            if (win_any) begin
                state     <= GRANT;
                gnt       <= win_oh;
                gnt_idx   <= win_idx;
                gnt_valid <= 1'b1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                ptr       <= (win_idx == '0) ? IDX_W'(N - 1) : win_idx - 1'b1;
`endif
            end else begin
                state     <= IDLE;
                gnt       <= '0;
                gnt_idx   <= '0;
                gnt_valid <= 1'b0;
            end
        end else begin
            timeout <= 1'b0;
            if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prio_arbiter_hold.sv
// Directed self-checking bench for prio_arbiter_hold (fixed priority by default,
// rotating-priority sequence when PRIO_ARB_ROUND_ROBIN_EN is defined).
module tb_prio_arbiter_hold;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef PRIO_ARB_ROUND_ROBIN_EN

    logic [3:0] req  = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    prio_arbiter_hold #(.N(4), .IDX_W(2), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    initial begin
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        #12;
        check("rr_reset", {gnt, gnt_idx, gnt_valid, timeout}, 32'h0);
        rst_n = 1'b1;
        cycle(2);
        check("rr_idle", {gnt, gnt_idx, gnt_valid, timeout}, 32'h0);
        req = 4'b1111;
        cycle(1);
        check("rr_first", 32'(gnt_idx), 32'(exp_seq[0]));
        for (int i = 1; i < 5; i++) begin
            done = 1'b1;
            cycle(1);
            check($sformatf("rr_seq%0d", i), 32'(gnt_idx), 32'(exp_seq[i]));
            check($sformatf("rr_oh%0d", i), 32'(gnt), 32'(4'b0001 << exp_seq[i]));
        end
        done = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

`else

    logic [7:0] req    = '0;
    logic       done   = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    logic [7:0] req_w  = '0;
    logic       done_w = 1'b0;
    logic [7:0] gnt_w;
    logic [2:0] gnt_idx_w;
    logic       gnt_valid_w;
    logic       timeout_w;

    prio_arbiter_hold #(.N(8), .IDX_W(3), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    prio_arbiter_hold #(.N(8), .IDX_W(3), .MAX_HOLD(4)) dut_wd (
        .clk(clk), .rst_n(rst_n), .req(req_w), .done(done_w),
        .gnt(gnt_w), .gnt_idx(gnt_idx_w), .gnt_valid(gnt_valid_w), .timeout(timeout_w)
    );

    initial begin
        // Reset and idle
        #12;
        check("reset", {gnt, gnt_idx, gnt_valid, timeout}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            check($sformatf("idle%0d", i), {gnt, gnt_idx, gnt_valid, timeout}, 32'h0);
        end

        // Fixed priority, then done-driven handover with no bubble
        req = 8'b0010_0101;
        cycle(1);
        check("prio_gnt", 32'(gnt), 32'h20);
        check("prio_idx", 32'(gnt_idx), 32'd5);
        check("prio_valid", 32'(gnt_valid), 32'd1);
        done = 1'b1;
        req  = 8'b0000_0101;
        cycle(1);
        done = 1'b0;
        check("handover_idx", 32'(gnt_idx), 32'd2);
        check("handover_gnt", 32'(gnt), 32'h04);
        check("handover_to", 32'(timeout), 32'd0);

        // Release to idle, then hold without preemption
        req = 8'b0000_0000;
        cycle(1);
        check("drop_idle", {gnt, gnt_idx, gnt_valid}, 32'h0);
        req = 8'b0000_1000;
        cycle(1);
        check("own3", 32'(gnt_idx), 32'd3);
        req = 8'b1000_1000;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            check($sformatf("hold%0d", i), 32'(gnt_idx), 32'd3);
        end
        req = 8'b1000_0000;
        cycle(1);
        check("after_drop_idx", 32'(gnt_idx), 32'd7);
        check("after_drop_gnt", 32'(gnt), 32'h80);

        // done while idle is ignored; the request still wins
        req = 8'b0000_0000;
        cycle(1);
        check("idle_again", 32'(gnt_valid), 32'd0);
        done = 1'b1;
        req  = 8'b0000_0010;
        cycle(1);
        done = 1'b0;
        check("idle_done_ignored", 32'(gnt_idx), 32'd1);
        check("idle_done_valid", 32'(gnt_valid), 32'd1);

        // Asynchronous reset between edges
        req = 8'b0010_0000;
        cycle(1);
        check("pre_rst_idx", 32'(gnt_idx), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {gnt, gnt_idx, gnt_valid, timeout}, 32'h0);
        rst_n = 1'b1;
        cycle(1);
        check("post_rst_idx", 32'(gnt_idx), 32'd5);
        req = 8'b0000_0000;

        // Watchdog with MAX_HOLD=4, other requester waiting
        req_w = 8'b0100_0010;
        cycle(1);
        check("wd_grant", 32'(gnt_idx_w), 32'd6);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            check($sformatf("wd_hold%0d", i), {gnt_idx_w, timeout_w}, {3'd6, 1'b0});
        end
        cycle(1);
        check("wd_to_pulse", 32'(timeout_w), 32'd1);
        check("wd_to_idx", 32'(gnt_idx_w), 32'd1);
        check("wd_to_gnt", 32'(gnt_w), 32'h02);
        cycle(1);
        check("wd_pulse_end", {gnt_idx_w, timeout_w}, {3'd1, 1'b0});

        // Lone requester times out: idle cycle, then re-granted
        req_w = 8'b0100_0000;
        cycle(1);
        check("wd_lone_grant", {gnt_idx_w, timeout_w}, {3'd6, 1'b0});
        cycle(3);
        check("wd_lone_hold", 32'(gnt_idx_w), 32'd6);
        cycle(1);
        check("wd_lone_to", {gnt_w, gnt_valid_w, timeout_w}, {8'h00, 1'b0, 1'b1});
        cycle(1);
        check("wd_lone_regrant", {gnt_idx_w, gnt_valid_w, timeout_w}, {3'd6, 1'b1, 1'b0});

        // done on the same edge as the watchdog limit is a normal release
        cycle(3);
        done_w = 1'b1;
        cycle(1);
        done_w = 1'b0;
        check("wd_done_same_edge", {gnt_idx_w, gnt_valid_w, timeout_w}, {3'd6, 1'b1, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

`endif

endmodule
